// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the 8N1 UART transmitter.
// The CPU register side uses the master modport; the transmitter uses the slave modport.
interface uart_tx_if;
  logic [7:0] in;
  logic       load;
  logic       tx;
  logic       busy;

  modport master (
    output in,
    output load,
    input  tx,
    input  busy
  );

  modport slave (
    input  in,
    input  load,
    output tx,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: captures a byte on load and sends start, eight data bits LSB first, and stop.
// tx and busy come straight from flops, so the line never glitches.
module uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end_s;

  assign bit_end_s = (baud_cnt_q == CNT_LAST);
  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;

  // Next-state logic; tx_d is the value the line takes in the following cycle.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        baud_cnt_d = {CW{1'b0}};
        if (bus.load) begin
          shift_d = bus.in;
          state_d = START;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
        end else begin
          shift_d = shift_q;
        end
      end
      START: begin
        if (bit_end_s) begin
          baud_cnt_d = {CW{1'b0}};
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          baud_cnt_d = {CW{1'b0}};
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          baud_cnt_d = {CW{1'b0}};
          state_d    = IDLE;
          busy_d     = 1'b0;
          tx_d       = 1'b1;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = {CW{1'b0}};
        bit_idx_d  = 3'd0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset; a reset mid-frame aborts it cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= {CW{1'b0}};
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule
